lfsr_mem_arbiter: RTL
=====================

# lfsr_mem_arbiter

Two-port arbiter and sequencer in front of the LFSR associative-memory control path. It accepts write and search requests from two requesters and grants them round-robin. For the granted request it issues a single-cycle write or read pulse to the memory control path and waits a fixed write latency or for a compare hit. A search that misses for too long is bounded by a timeout that forces a search abort. The requester then gets a one-cycle completion with found flag and match address.

## Interface
- `DATA_W`, default 8: width of search/write data word.
- `ADDR_W`, default 4: LFSR/match address width.
- `WR_LAT`, default 3: cycles to wait after a write pulse before completing.
- `SEARCH_MAX`, default 2**ADDR_W: SEARCH cycles allowed before abort.

Ports:
- `Clock`  in  1: single clock; all state updates on rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Req0`, `Req1`  in  1: level request; held until matching `Done`.
- `Op0`, `Op1`  in  1: 0 = write, 1 = search.
- `Data0`, `Data1`  in  DATA_W: write data or search key.
- `Grant0`, `Grant1`  out  1: one-cycle pulse when that port's request is issued.
- `Done0`, `Done1`  out  1: one-cycle completion pulse.
- `Found`  out  1: valid with `Done*`; 1 = search hit (always 0 for writes).
- `Match_Addr`  out  ADDR_W: valid with `Done*` when `Found`=1, else 0.
- `Mem_WR`, `Mem_RD`  out  1: one-cycle pulses into the control path's external write/read inputs.
- `Mem_Data`  out  DATA_W: latched request data, held from ISSUE through RESP.
- `Mem_Abort`  out  1: one-cycle pulse; system wiring ORs it into the control path's compare-found input to release LFSR search.
- `Mem_Compare_Found`  in  1: compare hit from datapath.
- `Mem_Match_Addr`  in  ADDR_W: LFSR address at hit.

## Operation
- States: IDLE, ISSUE, WR_WAIT, SEARCH, ABORT, RESP.
- **IDLE:**
  - If any `Req` is high, select a port. A single request wins. If both are high, the port named by the priority pointer wins.
  - Latch port id, `Op`, and `Data`, then go to ISSUE.
- **ISSUE (1 cycle):**
  - `Grant` of the selected port is high.
  - `Mem_WR` is high if op = 0; `Mem_RD` is high if op = 1.
  - Op 0 goes to WR_WAIT. Op 1 goes to SEARCH with the timer cleared.
- **WR_WAIT:** lasts exactly `WR_LAT` cycles, then RESP with `Found`=0.
- **SEARCH:**
  - Each cycle, if `Mem_Compare_Found`=1, latch `Mem_Match_Addr`, set found, and go to RESP.
  - Otherwise increment the timer. Once `SEARCH_MAX` cycles have elapsed without a hit, go to ABORT.
- **ABORT (1 cycle):** `Mem_Abort`=1, then RESP with `Found`=0 and `Match_Addr`=0.
- **RESP (1 cycle):**
  - `Done` of the served port is high; `Found` and `Match_Addr` are valid.
  - The priority pointer moves to the other port.
  - Go to IDLE.
- **Ignored inputs:** `Req`/`Op`/`Data` are sampled only in IDLE. A `Req` drop mid-operation does not cancel it; `Done` still pulses. `Mem_Compare_Found` is ignored outside SEARCH.
- **Hit vs timeout:** if a hit arrives in the last allowed SEARCH cycle, the hit wins and no abort is issued.
- **Timer width:** the timer is ADDR_W+1 bits and never wraps.
- **Reset values:**
  - All outputs are 0.
  - State is IDLE, the timer is 0, and the pointer selects port 0.
  - The latched data register is 0.
- **Reset mid-operation:** everything returns to IDLE immediately. No `Done` or `Mem_Abort` is generated. Recovering the memory control path is the system's responsibility.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- **Write:** `Req` high in IDLE cycle 0 gives ISSUE in cycle 1 (`Grant`, `Mem_WR`), WR_WAIT in cycles 2..1+WR_LAT, and `Done` in cycle 2+WR_LAT (cycle 5 at default).
- **Search hit:** ISSUE in cycle 1 (`Mem_RD`) and SEARCH from cycle 2. A hit sampled in SEARCH cycle k gives `Done`/`Found` in cycle k+1.
- **Search miss:** SEARCH occupies cycles 2..1+SEARCH_MAX, ABORT is cycle 2+SEARCH_MAX, and `Done` is cycle 3+SEARCH_MAX (cycle 19 at default).
- **Back-to-back:** the next IDLE follows RESP, so the minimum gap between grants is WR_LAT+3 cycles for writes.

## Structure
- **Shared package `lfsr_mem_pkg`:**
  - state encoding;
  - OP_WRITE/OP_SEARCH constants;
  - default DATA_W/ADDR_W, shared with the control path and datapath.
- **Sub-module `lfsr_search_timer`:**
  - clear/enable counter with an `expired` output at SEARCH_MAX;
  - reused for the WR_WAIT count by loading WR_LAT.

## Test plan
- **Single write:** Req0=1, Op0=0, Data0=8'hA5 → Grant0 in cycle 1, Mem_WR in cycle 1, Mem_Data=A5, Done0 in cycle 5, Found=0.
- **Search hit:** Req1=1, Op1=1, Mem_Compare_Found driven high in the 4th SEARCH cycle with Mem_Match_Addr=4'h9 → Done1 one cycle later, Found=1, Match_Addr=9, Mem_Abort never high.
- **Search timeout:** no hit → Mem_Abort pulses in cycle 18, Done in cycle 19 with Found=0 and Match_Addr=0. Repeat with the hit on the 16th SEARCH cycle → Found=1 and no abort.
- **Contention:** Req0=Req1=1 continuously → grants alternate 0,1,0,1 starting with port 0 after reset; each Done goes only to the granted port.
- **Request withdrawal:** Req0 drops during WR_WAIT → Done0 still pulses, and no second grant goes to port 0.
- **Reset mid-search:** Reset_n low in the 5th SEARCH cycle → all outputs 0 asynchronously. After release, the state is IDLE, Req1 high is granted to port 1 in cycle 1, and the pointer restarts at port 0.

Source files
------------

// File: rtl/lfsr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_mem_pkg
// Brief   : Shared types and constants for the LFSR associative-memory path.
// Rev     : 1.0 - initial release
// ============================================================================
package lfsr_mem_pkg;

    localparam int c_DATA_W_DEF = 8;
    localparam int c_ADDR_W_DEF = 4;

    localparam logic c_OP_WRITE  = 1'b0;
    localparam logic c_OP_SEARCH = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_ABORT   = 3'd4,
        ST_RESP    = 3'd5
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_search_timer.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_search_timer
// Brief   : Saturating clear/enable cycle counter with a last-cycle flag.
// Rev     : 1.0 - initial release
// ============================================================================
module lfsr_search_timer #(
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High during the cycle that completes i_limit enabled cycles.
    assign o_expired = i_enable && (r_count == (i_limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/lfsr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_mem_arbiter
// Brief   : Round-robin two-port arbiter/sequencer for LFSR memory write/search.
// Rev     : 1.0 - initial release
// ============================================================================
module lfsr_mem_arbiter
    import lfsr_mem_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W_DEF,
    parameter int ADDR_W     = c_ADDR_W_DEF,
    parameter int WR_LAT     = 3,
    parameter int SEARCH_MAX = 2**ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Op0,
    input  logic              Op1,
    input  logic [DATA_W-1:0] Data0,
    input  logic [DATA_W-1:0] Data1,
    output logic              Grant0,
    output logic              Grant1,
    output logic              Done0,
    output logic              Done1,
    output logic              Found,
    output logic [ADDR_W-1:0] Match_Addr,
    output logic              Mem_WR,
    output logic              Mem_RD,
    output logic [DATA_W-1:0] Mem_Data,
    output logic              Mem_Abort,
    input  logic              Mem_Compare_Found,
    input  logic [ADDR_W-1:0] Mem_Match_Addr
);

    localparam int                 c_TMR_W      = ADDR_W + 1;
    localparam logic [c_TMR_W-1:0] c_SEARCH_LIM = c_TMR_W'(SEARCH_MAX);
    localparam logic [c_TMR_W-1:0] c_WR_LIM     = c_TMR_W'(WR_LAT);

    arb_state_t r_state;
    logic       r_port;
    logic       r_op;
    logic       r_ptr;

    logic               w_pick;
    logic               w_sel_op;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_tmr_clear;
    logic               w_tmr_enable;
    logic               w_tmr_expired;
    logic [c_TMR_W-1:0] w_tmr_limit;

    // A lone requester always wins; the pointer only breaks ties.
    assign w_pick     = (Req0 && Req1) ? r_ptr : Req1;
    assign w_sel_op   = w_pick ? Op1 : Op0;
    assign w_sel_data = w_pick ? Data1 : Data0;

    assign w_tmr_clear  = (r_state == ST_ISSUE);
    assign w_tmr_enable = (r_state == ST_WR_WAIT) || (r_state == ST_SEARCH);
    assign w_tmr_limit  = (r_op == c_OP_SEARCH) ? c_SEARCH_LIM : c_WR_LIM;

    lfsr_search_timer #(
        .CNT_W (c_TMR_W)
    ) u_timer (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .i_limit   (w_tmr_limit),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_port     <= 1'b0;
            r_op       <= c_OP_WRITE;
            r_ptr      <= 1'b0;
            Grant0     <= 1'b0;
            Grant1     <= 1'b0;
            Done0      <= 1'b0;
            Done1      <= 1'b0;
            Found      <= 1'b0;
            Match_Addr <= '0;
            Mem_WR     <= 1'b0;
            Mem_RD     <= 1'b0;
            Mem_Data   <= '0;
            Mem_Abort  <= 1'b0;
        end else begin
            Grant0     <= 1'b0;
            Grant1     <= 1'b0;
            Done0      <= 1'b0;
            Done1      <= 1'b0;
            Found      <= 1'b0;
            Match_Addr <= '0;
            Mem_WR     <= 1'b0;
            Mem_RD     <= 1'b0;
            Mem_Abort  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (Req0 || Req1) begin
                        r_port   <= w_pick;
                        r_op     <= w_sel_op;
                        Mem_Data <= w_sel_data;
                        Grant0   <= !w_pick;
                        Grant1   <= w_pick;
                        Mem_WR   <= (w_sel_op == c_OP_WRITE);
                        Mem_RD   <= (w_sel_op == c_OP_SEARCH);
                        r_state  <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_state <= (r_op == c_OP_SEARCH) ? ST_SEARCH : ST_WR_WAIT;
                end

                ST_WR_WAIT: begin
                    if (w_tmr_expired) begin
                        Done0   <= !r_port;
                        Done1   <= r_port;
                        r_state <= ST_RESP;
                    end
                end

                ST_SEARCH: begin
                    // A hit in the final allowed cycle takes precedence over the abort.
                    if (Mem_Compare_Found) begin
                        Done0      <= !r_port;
                        Done1      <= r_port;
                        Found      <= 1'b1;
                        Match_Addr <= Mem_Match_Addr;
                        r_state    <= ST_RESP;
                    end else if (w_tmr_expired) begin
                        Mem_Abort <= 1'b1;
                        r_state   <= ST_ABORT;
                    end
                end

                ST_ABORT: begin
                    Done0   <= !r_port;
                    Done1   <= r_port;
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    r_ptr   <= !r_port;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
